instruction_queue: RTL
======================

# instruction_queue

Parametrised instruction register with prefetch buffering and immediate-word pairing. It sits between the data bus and the control unit. It accepts instruction words from the bus into a small FIFO and presents the decoded head instruction (opcode plus three register operands) to the controller. When an opcode announces an immediate, the following queued word is presented alongside it as the immediate.

## Interface
- WIDTH, 16, instruction word width.
- DEPTH, 4, queue depth in words. Must be a power of two and at least 2.
- OPCODE_W, 7, opcode field width.
- OPERAND_W, 3, operand field width. Required: OPCODE_W + 3*OPERAND_W == WIDTH.
- Clocking and reset: one clock, `clock`. Reset `notReset` is asynchronous and active-low.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- notReset  in  1  asynchronous active-low reset.
- notLoad  in  1  active-low write strobe; `in` is sampled at the rising edge.
- in  in  WIDTH  instruction/immediate word from the data bus.
- notAdvance  in  1  active-low; consumes the head instruction (and its immediate).
- notFlush  in  1  active-low synchronous queue clear.
- outValid  out  1  head instruction complete and presented.
- outOpcode  out  OPCODE_W  head word field [WIDTH-1 -: OPCODE_W].
- outOp0  out  OPERAND_W  next field below the opcode.
- outOp1  out  OPERAND_W  middle operand field.
- outOp2  out  OPERAND_W  field [OPERAND_W-1:0].
- outHasImm  out  1  opcode MSB of the head word.
- outImm  out  WIDTH  word following the head, when outHasImm.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  words currently stored.

## Operation
- Storage: DEPTH-word circular buffer with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
- Immediate rule: a head word whose opcode MSB is 1 owns the next stored word as its immediate.
- outValid:
  - Without immediate: outValid = (count >= 1).
  - With immediate: outValid = (count >= 2).
- Decode outputs are combinational from the head (and head+1) storage entries. They are forced to 0 whenever outValid = 0, except outHasImm, which reflects the head word whenever count >= 1.
- Load: accepted iff notLoad = 0, notFlush = 1, and count < DEPTH before the edge.
  - A load while full is dropped silently; state is unchanged and there is no error output.
  - full blocks a load even when an advance happens in the same cycle.
- Advance: effective iff notAdvance = 0, notFlush = 1, and outValid = 1.
  - Pops 1 word, or 2 words when outHasImm.
  - Advance while outValid = 0 is ignored.
- Simultaneous load and advance: both take effect. count_next = count + 1 − popped.
- Flush: highest priority. Pointers and count go to 0; any load or advance in the same cycle is discarded.
- Reset (any time, including mid-operation): pointers = 0, count = 0, so empty = 1, full = 0, outValid = 0, and all decode outputs = 0. Storage contents need not be cleared.

## Timing
- Load-to-output latency: 1 cycle. A word loaded at edge N is visible on the decode outputs after edge N, provided it is at the head.
- An immediate instruction becomes valid one edge after its immediate word is loaded.
- Advance takes effect at the edge. The new head is presented combinationally after that edge.
- Back-to-back: one load and one advance per cycle are sustained indefinitely when 0 < count < DEPTH.
- notReset deassertion is synchronised externally; the block needs no reset-release handling.
- No combinational path from any input to any output.

## Test plan
- Reset and single load: reset, then load 0x1234 with defaults -> next cycle outValid = 1, opcode = 0x09, op0 = 0, op1 = 6, op2 = 4, outHasImm = 0, count = 1. Advance -> empty = 1, outputs 0.
- Immediate pairing: load 0xF0F0 -> outHasImm = 1, outValid = 0. Load 0xBEEF -> outValid = 1, opcode = 0x78, op0 = 3, op1 = 6, op2 = 0, outImm = 0xBEEF. Advance -> count 2→0 in one cycle.
- Full/overflow: load 0x0001..0x0005 on consecutive cycles with DEPTH = 4 -> full = 1 after the 4th. 0x0005 is dropped. Drain by advancing -> heads read 0x0001..0x0004 in order, pointers wrap.
- Simultaneous load and advance at count = 2 -> count stays 2, order preserved. Load while full with advance asserted -> load dropped, count = 3.
- Flush priority: count = 3, assert notFlush = 0 together with notLoad = 0 and notAdvance = 0 -> count = 0 next cycle, loaded word absent.
- Async reset mid-stream: assert notReset between clock edges with count = 3 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first load behaves as in the first scenario.

Source files
------------

// File: rtl/instruction_queue.sv
// instruction_queue
//
// Prefetch queue between the data bus and the control unit. Words arriving
// from the bus are buffered in a small circular FIFO. The word at the head
// is decoded into an opcode and three register operands. When the opcode
// MSB is set, the head owns the following stored word as its immediate.
// In that case the instruction is only presented once both words are
// stored, and an advance pops both words together.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   notReset    asynchronous active-low reset
//   notLoad     active-low write strobe, `in` sampled at the rising edge
//   in          instruction/immediate word from the data bus
//   notAdvance  active-low, consumes the head instruction (and its immediate)
//   notFlush    active-low synchronous queue clear (highest priority)
//   outValid    head instruction complete and presented
//   outOpcode   opcode field of the head word
//   outOp0      operand field directly below the opcode
//   outOp1      middle operand field
//   outOp2      lowest operand field
//   outHasImm   opcode MSB of the head word (valid whenever count >= 1)
//   outImm      word following the head, when the head carries an immediate
//   full        count == DEPTH
//   empty       count == 0
//   count       number of words currently stored
//
// DEPTH must be a power of two and at least 2, and
// OPCODE_W + 3*OPERAND_W must equal WIDTH.

module instruction_queue #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int OPCODE_W  = 7,
    parameter int OPERAND_W = 3
) (
    input  logic                       clock,
    input  logic                       notReset,
    input  logic                       notLoad,
    input  logic [WIDTH-1:0]           in,
    input  logic                       notAdvance,
    input  logic                       notFlush,
    output logic                       outValid,
    output logic [OPCODE_W-1:0]        outOpcode,
    output logic [OPERAND_W-1:0]       outOp0,
    output logic [OPERAND_W-1:0]       outOp1,
    output logic [OPERAND_W-1:0]       outOp2,
    output logic                       outHasImm,
    output logic [WIDTH-1:0]           outImm,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage is not reset; only pointers and occupancy define what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic [WIDTH-1:0] head_word;
    logic [WIDTH-1:0] imm_word;
    logic             has_imm;
    logic             head_valid;
    logic             load_ok;
    logic             adv_ok;
    logic [CW-1:0]    pop_cnt;

    // Head and head+1 entries; the +1 index wraps naturally at PW bits.
    assign head_word = mem[rd_ptr_reg];
    assign imm_word  = mem[rd_ptr_reg + PW'(1)];

    // An immediate-carrying head needs its second word stored before it
    // can be presented.
    assign has_imm    = (count_reg != '0) && head_word[WIDTH-1];
    assign head_valid = has_imm ? (count_reg >= CW'(2)) : (count_reg != '0);

    // A full queue refuses the load even if an advance frees a slot in the
    // same cycle; this keeps full off the load path.
    assign load_ok = !notLoad && notFlush && (count_reg < CW'(DEPTH));
    assign adv_ok  = !notAdvance && notFlush && head_valid;
    assign pop_cnt = adv_ok ? (has_imm ? CW'(2) : CW'(1)) : '0;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (!notFlush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PW'(pop_cnt);
            wr_ptr_next = wr_ptr_reg + PW'(load_ok);
            count_next  = count_reg + CW'(load_ok) - pop_cnt;
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[wr_ptr_reg] <= in;
        end
    end

    // Decode outputs are gated by outValid so the controller never sees a
    // half-formed instruction. outHasImm is exposed earlier so the
    // controller can tell it is waiting on an immediate.
    always_comb begin
        outValid  = head_valid;
        outHasImm = has_imm;
        outOpcode = '0;
        outOp0    = '0;
        outOp1    = '0;
        outOp2    = '0;
        outImm    = '0;
        if (head_valid) begin
            outOpcode = head_word[WIDTH-1 -: OPCODE_W];
            outOp0    = head_word[WIDTH-OPCODE_W-1 -: OPERAND_W];
            outOp1    = head_word[2*OPERAND_W-1 -: OPERAND_W];
            outOp2    = head_word[OPERAND_W-1:0];
            if (has_imm) begin
                outImm = imm_word;
            end
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule
